// File: rtl/dma_xfer_seq_if.sv
// Bus/handshake bundle between the DMA transfer sequencer and its surroundings
// (start request, arbiter, memory port, FIFO strobes and status).
interface dma_xfer_seq_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  xfer_len;
  logic [1:0]        xfer_size;
  logic              bus_grant;
  logic              bus_req;
  logic [2:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              busy;
  logic              done_irq;
  logic              err;

  modport master (
    input  start, src_addr, dst_addr, xfer_len, xfer_size,
    input  bus_grant, mem_ack, fifo_full, fifo_empty,
    output bus_req, mem_cmd, mem_addr, fifo_wr, fifo_rd, busy, done_irq, err
  );

  modport slave (
    output start, src_addr, dst_addr, xfer_len, xfer_size,
    output bus_grant, mem_ack, fifo_full, fifo_empty,
    input  bus_req, mem_cmd, mem_addr, fifo_wr, fifo_rd, busy, done_irq, err
  );
endinterface

// File: rtl/dma_xfer_seq.sv
// DMA transfer sequencer: burst reads into a FIFO, then burst writes out of it.
// Optional abort input enabled by defining DMA_SEQ_ABORT_EN.
module dma_xfer_seq #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16,
  parameter int BURST  = 4
) (
  input logic clk0,
  input logic reset,
`ifdef DMA_SEQ_ABORT_EN
  input logic abort,
`endif
  dma_xfer_seq_if.master bus
);
  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] src_reg, dst_reg, mem_addr_reg;
  logic [LEN_W-1:0]  rem_reg;
  logic [1:0]        size_reg;
  logic [CNT_W-1:0]  burst_cnt_reg;
  logic              inflight_reg, popped_reg, pend_wr_reg;
  logic              bus_req_reg, fifo_rd_reg, busy_reg, done_irq_reg, err_reg;
  logic [2:0]        mem_cmd_reg;
`ifdef DMA_SEQ_ABORT_EN
  logic              abort_pend_reg;
  logic              abort_hit;
  assign abort_hit = abort_pend_reg | abort;
`endif

  logic [LEN_W-1:0]  step_len, start_step;
  logic [ADDR_W-1:0] step_addr;
  logic [CNT_W-1:0]  cnt_inc;
  logic              start_bad, rd_burst_end, phase_wr;

  assign step_len     = LEN_W'(1) << size_reg;
  assign step_addr    = ADDR_W'(1) << size_reg;
  assign start_step   = LEN_W'(1) << bus.xfer_size;
  assign start_bad    = (bus.xfer_len == '0) || (bus.xfer_size == 2'b11) ||
                        ((bus.xfer_len & (start_step - LEN_W'(1))) != '0);
  assign cnt_inc      = burst_cnt_reg + CNT_W'(1);
  // Reads stop once the burst is full or every remaining unit is already buffered.
  assign rd_burst_end = (cnt_inc == CNT_W'(BURST)) ||
                        ((LEN_W'(cnt_inc) << size_reg) == rem_reg);
  assign phase_wr     = (state_reg == WR) || ((state_reg == REQ) && pend_wr_reg);

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      rem_reg       <= '0;
      size_reg      <= '0;
      burst_cnt_reg <= '0;
      inflight_reg  <= 1'b0;
      popped_reg    <= 1'b0;
      pend_wr_reg   <= 1'b0;
      bus_req_reg   <= 1'b0;
      mem_cmd_reg   <= 3'b000;
      mem_addr_reg  <= '0;
      fifo_rd_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_irq_reg  <= 1'b0;
      err_reg       <= 1'b0;
`ifdef DMA_SEQ_ABORT_EN
      abort_pend_reg <= 1'b0;
`endif
    end else begin
      fifo_rd_reg  <= 1'b0;
      done_irq_reg <= 1'b0;
      err_reg      <= 1'b0;
`ifdef DMA_SEQ_ABORT_EN
      if (abort && (state_reg == REQ || state_reg == RD || state_reg == WR))
        abort_pend_reg <= 1'b1;
`endif
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (start_bad) begin
              err_reg <= 1'b1;
            end else begin
              src_reg       <= bus.src_addr;
              dst_reg       <= bus.dst_addr;
              rem_reg       <= bus.xfer_len;
              size_reg      <= bus.xfer_size;
              burst_cnt_reg <= '0;
              pend_wr_reg   <= 1'b0;
              bus_req_reg   <= 1'b1;
              busy_reg      <= 1'b1;
              state_reg     <= REQ;
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
`ifdef DMA_SEQ_ABORT_EN
          abort_pend_reg <= 1'b0;
`endif
        end
        default: begin
          if (inflight_reg) begin
            if (bus.mem_ack) begin
              inflight_reg <= 1'b0;
              mem_cmd_reg  <= 3'b000;
              if (state_reg == RD) begin
                src_reg       <= src_reg + step_addr;
                burst_cnt_reg <= cnt_inc;
                if (rd_burst_end) state_reg <= WR;
              end else begin
                dst_reg       <= dst_reg + step_addr;
                rem_reg       <= rem_reg - step_len;
                burst_cnt_reg <= burst_cnt_reg - CNT_W'(1);
                if (rem_reg == step_len) begin
                  bus_req_reg  <= 1'b0;
                  done_irq_reg <= 1'b1;
                  state_reg    <= DONE;
                end else if (burst_cnt_reg == CNT_W'(1)) begin
                  state_reg <= RD;
                end
              end
            end
          end else if (popped_reg) begin
            // The pop already committed this write; grant was checked before the pop.
            popped_reg   <= 1'b0;
            inflight_reg <= 1'b1;
            mem_cmd_reg  <= 3'b010;
            mem_addr_reg <= dst_reg;
`ifdef DMA_SEQ_ABORT_EN
          end else if (abort_hit) begin
            bus_req_reg  <= 1'b0;
            done_irq_reg <= 1'b1;
            err_reg      <= 1'b1;
            state_reg    <= DONE;
`endif
          end else if (!bus.bus_grant) begin
            pend_wr_reg <= phase_wr;
            state_reg   <= REQ;
          end else if (phase_wr) begin
            state_reg <= WR;
            if (!bus.fifo_empty) begin
              fifo_rd_reg <= 1'b1;
              popped_reg  <= 1'b1;
            end
          end else begin
            state_reg <= RD;
            if (!bus.fifo_full) begin
              inflight_reg <= 1'b1;
              mem_cmd_reg  <= 3'b001;
              mem_addr_reg <= src_reg;
            end
          end
        end
      endcase
    end
  end

  // The FIFO push has to coincide with the read acknowledge itself.
  assign bus.fifo_wr  = inflight_reg && (state_reg == RD) && bus.mem_ack;
  assign bus.bus_req  = bus_req_reg;
  assign bus.mem_cmd  = mem_cmd_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.fifo_rd  = fifo_rd_reg;
  assign bus.busy     = busy_reg;
  assign bus.done_irq = done_irq_reg;
  assign bus.err      = err_reg;
endmodule

// File: tb/tb_dma_xfer_seq.sv
// Self-checking bench for dma_xfer_seq: directed cases plus randomized transfers
// compared against an access-list model built from the transfer rules.
module tb_dma_xfer_seq;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 16;
  localparam int BURST  = 4;

  logic clk0 = 1'b0;
  logic reset = 1'b1;
  always #5 clk0 = ~clk0;

  dma_xfer_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

`ifdef DMA_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  dma_xfer_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST(BURST)) dut (
    .clk0  (clk0),
    .reset (reset),
`ifdef DMA_SEQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } acc_t;

  acc_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_fifo_wr = 0, n_fifo_rd = 0, n_done = 0;

  logic rnd_en = 1'b0;
  logic man_grant = 1'b1, man_full = 1'b0, man_empty = 1'b0;
  logic rnd_grant = 1'b1, rnd_full = 1'b0, rnd_empty = 1'b0;
  assign bus.bus_grant  = rnd_en ? rnd_grant : man_grant;
  assign bus.fifo_full  = rnd_en ? rnd_full  : man_full;
  assign bus.fifo_empty = rnd_en ? rnd_empty : man_empty;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk0);
    #1;
  endtask

  // Expected access order: per burst, up to BURST reads then the same count of writes.
  task automatic build_model(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input int len, input int sz);
    int step, units, done_u, n;
    acc_t a;
    step   = 1 << sz;
    units  = len / step;
    done_u = 0;
    while (done_u < units) begin
      n = (units - done_u < BURST) ? units - done_u : BURST;
      for (int i = 0; i < n; i++) begin
        a.cmd = 3'b001; a.addr = s + ADDR_W'((done_u + i) * step); exp_q.push_back(a);
      end
      for (int i = 0; i < n; i++) begin
        a.cmd = 3'b010; a.addr = d + ADDR_W'((done_u + i) * step); exp_q.push_back(a);
      end
      done_u += n;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_bus_req"},  bus.bus_req,  0);
    check_val({tag, "_mem_cmd"},  bus.mem_cmd,  0);
    check_val({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_val({tag, "_fifo_wr"},  bus.fifo_wr,  0);
    check_val({tag, "_fifo_rd"},  bus.fifo_rd,  0);
    check_val({tag, "_busy"},     bus.busy,     0);
    check_val({tag, "_done_irq"}, bus.done_irq, 0);
    check_val({tag, "_err"},      bus.err,      0);
  endtask

  // Memory responder and random arbiter/FIFO status.
  initial begin
    logic seen;
    int   wait_n;
    seen = 1'b0;
    wait_n = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk0);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_cmd != 3'b000) begin
        if (!seen) begin
          seen = 1'b1;
          wait_n = rnd_en ? $urandom_range(0, 2) : 0;
        end else if (wait_n == 0) begin
          bus.mem_ack = 1'b1;
          seen = 1'b0;
        end else begin
          wait_n--;
        end
      end else begin
        seen = 1'b0;
      end
      rnd_grant = ($urandom_range(0, 5) != 0);
      rnd_full  = ($urandom_range(0, 4) == 0);
      rnd_empty = ($urandom_range(0, 4) == 0);
    end
  end

  // Access monitor: every new command must be the next one the model predicts.
  initial begin
    logic [2:0] prev_cmd;
    logic       prev_grant, prev2_grant, prev_full, prev_empty, prev2_empty, prev_rd;
    acc_t       e;
    prev_cmd = 3'b000; prev_grant = 1'b0; prev2_grant = 1'b0;
    prev_full = 1'b0; prev_empty = 1'b0; prev2_empty = 1'b0; prev_rd = 1'b0;
    forever begin
      @(negedge clk0);
      if (bus.mem_cmd != 3'b000 && prev_cmd == 3'b000) begin
        if (exp_q.size() == 0) begin
          check_val("extra_cmd", bus.mem_cmd, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("cmd", bus.mem_cmd, e.cmd);
          check_val("addr", bus.mem_addr, e.addr);
          if (e.cmd == 3'b001) begin
            check_val("rd_grant", prev_grant, 1);
            check_val("rd_not_full", prev_full, 0);
          end else begin
            check_val("wr_pop_before", prev_rd, 1);
            check_val("wr_grant", prev2_grant, 1);
            check_val("wr_not_empty", prev2_empty, 0);
          end
        end
      end
      if (bus.fifo_wr) begin
        n_fifo_wr++;
        check_val("fifo_wr_with_ack", {bus.mem_ack, bus.mem_cmd}, {1'b1, 3'b001});
      end
      if (bus.fifo_rd) n_fifo_rd++;
      if (bus.done_irq) n_done++;
      prev2_grant = prev_grant;
      prev2_empty = prev_empty;
      prev_grant  = bus.bus_grant;
      prev_full   = bus.fifo_full;
      prev_empty  = bus.fifo_empty;
      prev_cmd    = bus.mem_cmd;
      prev_rd     = bus.fifo_rd;
    end
  end

  // mode 0: plain, 1: grant dropped after 2nd read ack, 2: FIFO full during RD
  task automatic run_xfer(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input int len, input int sz, input int mode, input bit chk_lat);
    int units, cyc;
    units = len / (1 << sz);
    build_model(s, d, len, sz);
    n_fifo_wr = 0; n_fifo_rd = 0; n_done = 0;
    if (mode == 2) man_full = 1'b1;
    bus.src_addr = s; bus.dst_addr = d;
    bus.xfer_len = LEN_W'(len); bus.xfer_size = 2'(sz);
    bus.start = 1'b1;
    step_cycle();
    bus.start = 1'b0;
    if (chk_lat) begin
      cyc = 1;
      while (bus.mem_cmd != 3'b001 && cyc < 50) begin step_cycle(); cyc++; end
      check_val("start_latency", cyc, 2);
    end
    if (mode == 1) begin
      cyc = 0;
      while (n_fifo_wr < 2 && cyc < 200) begin step_cycle(); cyc++; end
      check_val("grant_drop_reads", n_fifo_wr, 2);
      man_grant = 1'b0;
      for (int i = 0; i < 6; i++) begin
        check_val("grant_low_bus_req", bus.bus_req, 1);
        check_val("grant_low_mem_cmd", bus.mem_cmd, 0);
        step_cycle();
      end
      man_grant = 1'b1;
    end
    if (mode == 2) begin
      for (int i = 0; i < 6; i++) begin
        step_cycle();
        check_val("full_stall_mem_cmd", bus.mem_cmd, 0);
        check_val("full_stall_fifo_wr", bus.fifo_wr, 0);
        check_val("full_stall_bus_req", bus.bus_req, 1);
      end
      man_full = 1'b0;
    end
    cyc = 0;
    while (n_done == 0 && cyc < 4000) begin step_cycle(); cyc++; end
    step_cycle();
    step_cycle();
    check_val("done_count", n_done, 1);
    check_val("fifo_wr_count", n_fifo_wr, units);
    check_val("fifo_rd_count", n_fifo_rd, units);
    check_val("accesses_left", exp_q.size(), 0);
    check_val("busy_after", bus.busy, 0);
    check_val("bus_req_after", bus.bus_req, 0);
    $display("xfer src=%06h dst=%06h len=%0d size=%0d mode=%0d cycles=%0d done=%0d",
             s, d, len, sz, mode, cyc, n_done);
    exp_q.delete();
  endtask

  task automatic illegal_start(input int len, input int sz);
    n_done = 0;
    bus.xfer_len = LEN_W'(len); bus.xfer_size = 2'(sz);
    bus.src_addr = 24'h000300; bus.dst_addr = 24'h000400;
    bus.start = 1'b1;
    step_cycle();
    bus.start = 1'b0;
    check_val("illegal_err", bus.err, 1);
    check_val("illegal_busy", bus.busy, 0);
    check_val("illegal_bus_req", bus.bus_req, 0);
    step_cycle();
    check_val("illegal_err_clear", bus.err, 0);
    check_val("illegal_busy_later", bus.busy, 0);
    check_val("illegal_bus_req_later", bus.bus_req, 0);
    $display("illegal start len=%0d size=%0d err_pulse_checked", len, sz);
  endtask

  initial begin
    int cyc, sz, units;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.xfer_len = '0; bus.xfer_size = 2'b00;
    repeat (3) step_cycle();
    check_all_zero("reset");
    reset = 1'b0;
    step_cycle();

    run_xfer(24'h000100, 24'h000200, 8, 2, 0, 1'b1);
    run_xfer(24'h000010, 24'h000020, 6, 0, 0, 1'b1);
    illegal_start(3, 1);
    illegal_start(0, 2);
    illegal_start(8, 3);
    illegal_start(6, 2);
    run_xfer(24'h000040, 24'h000080, 16, 2, 1, 1'b0);
    run_xfer(24'h000500, 24'h000600, 10, 1, 2, 1'b0);
    run_xfer(24'hFFFFFC, 24'h000010, 8, 2, 0, 1'b1);

    // Reset asserted in the middle of a write access.
    build_model(24'h000700, 24'h000800, 8, 2);
    n_done = 0;
    bus.src_addr = 24'h000700; bus.dst_addr = 24'h000800;
    bus.xfer_len = 16'd8; bus.xfer_size = 2'b10;
    bus.start = 1'b1;
    step_cycle();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.mem_cmd != 3'b010 && cyc < 100) begin step_cycle(); cyc++; end
    check_val("mid_wr_reached", bus.mem_cmd, 3'b010);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("mid_wr_reset");
    exp_q.delete();
    repeat (2) step_cycle();
    reset = 1'b0;
    repeat (6) step_cycle();
    check_val("no_done_after_reset", n_done, 0);
    check_val("idle_after_reset", bus.busy, 0);
    $display("reset during write: outputs cleared, transfer abandoned");

    rnd_en = 1'b1;
    for (int t = 0; t < 24; t++) begin
      sz = $urandom_range(0, 2);
      units = $urandom_range(1, 11);
      run_xfer(ADDR_W'($urandom), ADDR_W'($urandom), units << sz, sz, 0, 1'b0);
    end
    rnd_en = 1'b0;
    repeat (2) step_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dma_xfer_seq.md
DMA_XFER_SEQ -- requirements
Module: dma_xfer_seq

Interface
REQ-001 Parameter ADDR_W, default 24, SHALL set the bus address width.
REQ-002 Parameter LEN_W, default 16, SHALL set the byte-count width.
REQ-003 Parameter BURST, default 4, SHALL set the maximum units per read/write burst and SHALL be no greater than the FIFO depth.
REQ-004 clk0  in  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be asynchronous and active-high.
REQ-006 start  in  1  SHALL be a one-cycle pulse that begins a transfer.
REQ-007 src_addr, dst_addr  in  ADDR_W  SHALL be the source and destination start addresses, sampled on start.
REQ-008 xfer_len  in  LEN_W  SHALL be the byte count, sampled on start.
REQ-009 xfer_size  in  2  SHALL select the unit size: 00 byte, 01 halfword, 10 word; 11 SHALL be illegal.
REQ-010 bus_grant  in  1  SHALL be the arbiter grant.
REQ-011 bus_req  out  1  SHALL be the bus request.
REQ-012 mem_cmd  out  3  SHALL carry 3'b001 for read, 3'b010 for write, and 3'b000 when idle.
REQ-013 mem_addr  out  ADDR_W  SHALL carry the current access address.
REQ-014 mem_ack  in  1  SHALL be a one-cycle pulse marking completion of the current access.
REQ-015 fifo_wr, fifo_rd  out  1  SHALL be one-cycle FIFO push and pop strobes.
REQ-016 fifo_full, fifo_empty  in  1  SHALL be the FIFO status flags.
REQ-017 busy  out  1  SHALL be high from the cycle after an accepted start until DONE is left.
REQ-018 done_irq  out  1  SHALL pulse for one cycle at transfer completion.
REQ-019 err  out  1  SHALL pulse for one cycle when a start is rejected.

Function
REQ-020 The FSM states SHALL be IDLE, REQ, RD, WR, DONE.
REQ-021 IDLE + start SHALL proceed as follows:
- Reject the start, pulse err, and stay in IDLE if xfer_len is 0, xfer_size is 11, or xfer_len is not a multiple of the step.
- The step SHALL be 1, 2 or 4.
- Otherwise latch src_addr, dst_addr and xfer_len and enter REQ.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 In REQ:
- bus_req SHALL be 1.
- On bus_grant=1 the FSM SHALL enter the phase that is pending: RD initially, or the phase that was interrupted.
REQ-024 In RD:
- Drive mem_cmd=001 and mem_addr=src.
- On mem_ack, pulse fifo_wr in the same cycle, add step to src, and increment the burst count.
- On BURST units, or when the remaining length reaches 0, enter WR.
REQ-025 In WR:
- Drive mem_cmd=010 and mem_addr=dst.
- fifo_rd SHALL pulse one cycle before each write access is issued.
- On mem_ack, add step to dst and subtract step from the remaining length.
- When the burst is drained: go to DONE if remaining=0, else to RD.
REQ-026 If bus_grant is low at the start of any access, the FSM SHALL:
- Go to REQ with bus_req held high.
- Suspend the access.
- Resume the same phase and address.
An in-flight access SHALL always complete.
REQ-027 A read SHALL NOT be issued while fifo_full=1, and a write SHALL NOT be issued while fifo_empty=1; the FSM SHALL stall in place.
REQ-028 DONE SHALL:
- Pulse done_irq.
- Drop bus_req.
- Drop busy.
- Return to IDLE next cycle.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W; wrap SHALL NOT be flagged.
REQ-030 The remaining length SHALL never underflow, since lengths are step-aligned by REQ-021.
REQ-031 The start-to-first-read-command latency SHALL be 2 cycles when bus_grant is already high.

Reset
REQ-032 Reset SHALL force IDLE and clear all outputs (bus_req, mem_cmd, mem_addr, fifo_wr, fifo_rd, busy, done_irq, err) and all internal counters to 0 immediately.
REQ-033 Reset mid-transfer SHALL abandon the transfer; done_irq SHALL NOT pulse.

Configuration
REQ-034 When DMA_SEQ_ABORT_EN is defined, an input abort (1 bit) SHALL exist:
- An abort pulse in REQ/RD/WR SHALL finish any in-flight access.
- It SHALL then drop bus_req and enter DONE, pulsing done_irq and err together.
REQ-035 When DMA_SEQ_ABORT_EN is undefined, the abort port and its logic SHALL be absent; transfers SHALL run to completion.

Verification
REQ-036 Word transfer:
- Stimulus: start, src=0x000100, dst=0x000200, len=8, size=10, grant tied high, ack one cycle after each command.
- Response: reads at 0x100 and 0x104, then writes at 0x200 and 0x204, one done_irq.
REQ-037 Multi-burst byte transfer:
- Stimulus: len=6, size=00, BURST=4.
- Response: 4 reads, 4 writes, 2 reads, 2 writes, then done_irq.
REQ-038 Illegal start:
- Stimulus: len=3, size=01.
- Response: err pulse, busy stays 0, no bus_req.
REQ-039 Grant drop:
- Stimulus: bus_grant dropped after the 2nd read ack.
- Response: bus_req stays 1, no new command; the 3rd read resumes at src+2*step after the grant returns.
REQ-040 Full-FIFO stall:
- Stimulus: fifo_full=1 during RD.
- Response: mem_cmd=000 until fifo_full=0, no fifo_wr.
REQ-041 Reset and wrap:
- Stimulus: reset asserted mid-WR.
- Response: all outputs 0 in the same cycle.
- Separate wrap case: src=0xFFFFFC, size=10, len=8; the second read SHALL be at 0x000000.
